// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: pattern mode
// encodings, colour-bar palette and the standard timing constant sets.
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_SOLID = 2'd0,
      MODE_GRID  = 2'd1,
      MODE_BARS  = 2'd2,
      MODE_OFF   = 2'd3
   } vga_mode_e;

   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   // 1024x768@60, 1344x806 total
   localparam int unsigned XGA_H_ACTIVE = 1024;
   localparam int unsigned XGA_H_FP     = 24;
   localparam int unsigned XGA_H_SYNC   = 136;
   localparam int unsigned XGA_H_BP     = 160;
   localparam int unsigned XGA_V_ACTIVE = 768;
   localparam int unsigned XGA_V_FP     = 3;
   localparam int unsigned XGA_V_SYNC   = 6;
   localparam int unsigned XGA_V_BP     = 29;

   // 640x480@60, 800x525 total
   localparam int unsigned VGA640_H_ACTIVE = 640;
   localparam int unsigned VGA640_H_FP     = 16;
   localparam int unsigned VGA640_H_SYNC   = 96;
   localparam int unsigned VGA640_H_BP     = 48;
   localparam int unsigned VGA640_V_ACTIVE = 480;
   localparam int unsigned VGA640_V_FP     = 10;
   localparam int unsigned VGA640_V_SYNC   = 2;
   localparam int unsigned VGA640_V_BP     = 33;

   // Bar index 0..7 maps left to right across the screen
   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_pattern.sv
// Test-pattern source. Works on the same pixel the timing counters point at
// this cycle and registers the colour so it lines up with the registered
// sync/de outputs of the top level.
module vga_pattern
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned GRID     = 48,
   parameter logic [23:0] FG_COLOR = 24'hB93E06
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        de,
   input  logic        line_start,
   input  logic        frame_start,
   input  logic [1:0]  mode,
   output logic [23:0] rgb
);

   localparam logic [10:0] GRID_LAST = 11'(GRID - 1);
   localparam logic [10:0] BW_LAST   = 11'((H_ACTIVE / 8) - 1);

   logic [10:0] gx_q, gx_d, gx_cur;
   logic [10:0] gy_q, gy_d, gy_cur;
   logic [2:0]  bar_q, bar_d, bar_cur;
   logic [10:0] bc_q, bc_d, bc_cur;
   logic [23:0] rgb_q, rgb_d;

   // The "_cur" values are the counters as seen by the current pixel: the
   // line/frame strobes force a restart so no end-of-line cleanup is needed.
   always_comb begin
      gx_cur  = line_start ? 11'd0 : gx_q;
      bar_cur = line_start ? 3'd0  : bar_q;
      bc_cur  = line_start ? 11'd0 : bc_q;
      gy_cur  = gy_q;
      if (frame_start) begin
         gy_cur = 11'd0;
      end else if (line_start) begin
         gy_cur = (gy_q == GRID_LAST) ? 11'd0 : gy_q + 11'd1;
      end

      gx_d  = gx_q;
      gy_d  = gy_cur;
      bar_d = bar_cur;
      bc_d  = bc_cur;
      if (de) begin
         gx_d = (gx_cur == GRID_LAST) ? 11'd0 : gx_cur + 11'd1;
         if (bar_cur != 3'd7) begin
            if (bc_cur == BW_LAST) begin
               bar_d = bar_cur + 3'd1;
               bc_d  = 11'd0;
            end else begin
               bc_d = bc_cur + 11'd1;
            end
         end
      end

      rgb_d = 24'h000000;
      if (de) begin
         case (vga_mode_e'(mode))
            MODE_SOLID: rgb_d = FG_COLOR;
            MODE_GRID:  rgb_d = ((gx_cur == 11'd0) || (gy_cur == 11'd0)) ? 24'h000000 : FG_COLOR;
            MODE_BARS:  rgb_d = bar_color(bar_cur);
            default:    rgb_d = 24'h000000;
         endcase
      end
   end

   // Pattern counters and the registered colour, cleared by the shared reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         gx_q  <= 11'd0;
         gy_q  <= 11'd0;
         bar_q <= 3'd0;
         bc_q  <= 11'd0;
         rgb_q <= 24'h000000;
      end else begin
         gx_q  <= gx_d;
         gy_q  <= gy_d;
         bar_q <= bar_d;
         bc_q  <= bc_d;
         rgb_q <= rgb_d;
      end
   end

   assign rgb = rgb_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and data-enable
// generation, frame-aligned pattern mode latch and the pattern source.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 136,
   parameter int unsigned H_BP     = 160,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 29,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned GRID     = 48,
   parameter logic [23:0] FG_COLOR = 24'hB93E06
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mode,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        frame_start,
   output logic        line_start
);

   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] hc_q, hc_d;
   logic [10:0] vc_q, vc_d;
   logic [1:0]  mode_q, mode_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        de_q, de_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic        frame_start_q, frame_start_d;
   logic        line_start_q, line_start_d;
   logic        h_wrap, v_wrap;
   logic        de_c, line_start_c, frame_start_c;
   logic [23:0] rgb;

   // Counter advance, mode latch and the decode of the current pixel; every
   // decoded value is registered so all outputs trail the counters by one clock
   always_comb begin
      h_wrap = (hc_q == H_LAST);
      v_wrap = (vc_q == V_LAST);

      hc_d = h_wrap ? 11'd0 : hc_q + 11'd1;
      vc_d = vc_q;
      if (h_wrap) begin
         vc_d = v_wrap ? 11'd0 : vc_q + 11'd1;
      end

      mode_d = mode_q;
      if (h_wrap && v_wrap) begin
         mode_d = mode;
      end

      de_c          = (hc_q < H_ACT) && (vc_q < V_ACT);
      line_start_c  = (hc_q == 11'd0) && (vc_q < V_ACT);
      frame_start_c = (hc_q == 11'd0) && (vc_q == 11'd0);

      hsync_d       = ((hc_q >= HS_START) && (hc_q <= HS_END)) ? HS_POL : !HS_POL;
      vsync_d       = ((vc_q >= VS_START) && (vc_q <= VS_END)) ? VS_POL : !VS_POL;
      de_d          = de_c;
      x_d           = de_c ? hc_q : 11'd0;
      y_d           = de_c ? vc_q : 11'd0;
      line_start_d  = line_start_c;
      frame_start_d = frame_start_c;
   end

   // Counters and output registers; reset restarts the raster at the top-left
   // pixel and captures the requested pattern mode immediately
   always_ff @(posedge clk) begin
      if (!reset) begin
         hc_q          <= 11'd0;
         vc_q          <= 11'd0;
         mode_q        <= mode;
         hsync_q       <= !HS_POL;
         vsync_q       <= !VS_POL;
         de_q          <= 1'b0;
         x_q           <= 11'd0;
         y_q           <= 11'd0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         mode_q        <= mode_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
      end
   end

   vga_pattern #(
      .H_ACTIVE (H_ACTIVE),
      .GRID     (GRID),
      .FG_COLOR (FG_COLOR)
   ) u_pattern (
      .clk         (clk),
      .reset       (reset),
      .de          (de_c),
      .line_start  (line_start_c),
      .frame_start (frame_start_c),
      .mode        (mode_q),
      .rgb         (rgb)
   );

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;
   assign red         = rgb[23:16];
   assign green       = rgb[15:8];
   assign blue        = rgb[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. A small raster (28x15 total, 20x10
// visible, positive hsync, GRID=4) keeps frames short; a second instance with
// the 640x480 constant set checks line timing at a real resolution.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int HT = 28;
   localparam int VT = 15;
   localparam logic [23:0] FG = 24'hB93E06;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mode;

   logic        hsync, vsync, de, frame_start, line_start;
   logic [10:0] x, y;
   logic [7:0]  red, green, blue;

   logic        hsync_b, vsync_b, de_b, frame_start_b, line_start_b;
   logic [10:0] x_b, y_b;
   logic [7:0]  red_b, green_b, blue_b;

   int check_count = 0;
   int error_count = 0;
   int tb_h = 0;
   int tb_v = 0;

   vga_timing_gen #(
      .H_ACTIVE (20), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (1),
      .HS_POL (1'b1), .VS_POL (1'b0), .GRID (4), .FG_COLOR (FG)
   ) dut (
      .clk (clk), .reset (reset), .mode (mode),
      .hsync (hsync), .vsync (vsync), .de (de), .x (x), .y (y),
      .red (red), .green (green), .blue (blue),
      .frame_start (frame_start), .line_start (line_start)
   );

   vga_timing_gen #(
      .H_ACTIVE (VGA640_H_ACTIVE), .H_FP (VGA640_H_FP), .H_SYNC (VGA640_H_SYNC), .H_BP (VGA640_H_BP),
      .V_ACTIVE (VGA640_V_ACTIVE), .V_FP (VGA640_V_FP), .V_SYNC (VGA640_V_SYNC), .V_BP (VGA640_V_BP),
      .HS_POL (1'b0), .VS_POL (1'b0), .GRID (48), .FG_COLOR (FG)
   ) dut_640 (
      .clk (clk), .reset (reset), .mode (mode),
      .hsync (hsync_b), .vsync (vsync_b), .de (de_b), .x (x_b), .y (y_b),
      .red (red_b), .green (green_b), .blue (blue_b),
      .frame_start (frame_start_b), .line_start (line_start_b)
   );

   // Free-running pixel clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic reset_value, input logic [1:0] mode_value);
      reset = reset_value;
      mode  = mode_value;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic trackCycles(input int n);
      int pos;
      pos  = (tb_v * HT + tb_h + n) % (HT * VT);
      tb_h = pos % HT;
      tb_v = pos / HT;
   endtask

   task automatic gotoPixel(input int h, input int v);
      int n;
      n = (v * HT + h) - (tb_v * HT + tb_h);
      if (n < 0) n += HT * VT;
      repeat (n) @(posedge clk);
      #1;
      tb_h = h;
      tb_v = v;
   endtask

   task automatic checkRgb(input string tag, input int h, input int v, input logic [23:0] expected);
      gotoPixel(h, v);
      checkOutput(tag, 32'({red, green, blue}), 32'(expected));
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_hsync"}, 32'(hsync), 32'd0);
      checkOutput({tag, "_vsync"}, 32'(vsync), 32'd1);
      checkOutput({tag, "_de"}, 32'(de), 32'd0);
      checkOutput({tag, "_x"}, 32'(x), 32'd0);
      checkOutput({tag, "_y"}, 32'(y), 32'd0);
      checkOutput({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
      checkOutput({tag, "_fs"}, 32'(frame_start), 32'd0);
      checkOutput({tag, "_ls"}, 32'(line_start), 32'd0);
   endtask

   task automatic applyReset(input logic [1:0] m);
      applyStimulus(1'b0, m);
      stepClock();
      stepClock();
      checkResetValues("rst");
      applyStimulus(1'b1, m);
      stepClock();
      tb_h = 0;
      tb_v = 0;
   endtask

   // Watchdog so the run always ends even if the bench stalls
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      int n, cnt_a, cnt_b, first_low;
      applyStimulus(1'b0, 2'd0);

      // 640x480 line timing, measured from the first pixel after release
      applyReset(2'd0);
      checkOutput("vga640_hsync_idle", 32'(hsync_b), 32'd1);
      n = 0; cnt_a = 0; first_low = -1;
      do begin
         stepClock();
         n++;
         if (!hsync_b) begin
            cnt_a++;
            if (first_low < 0) first_low = n;
         end
      end while (!line_start_b && n < 2000);
      trackCycles(n);
      checkOutput("vga640_line_period", 32'(n), 32'd800);
      checkOutput("vga640_hsync_width", 32'(cnt_a), 32'd96);
      checkOutput("vga640_hsync_start", 32'(first_low), 32'd656);

      // Reset state and first frame geometry in solid mode
      applyReset(2'd0);
      checkOutput("p00_fs", 32'(frame_start), 32'd1);
      checkOutput("p00_ls", 32'(line_start), 32'd1);
      checkOutput("p00_de", 32'(de), 32'd1);
      checkOutput("p00_x", 32'(x), 32'd0);
      checkOutput("p00_y", 32'(y), 32'd0);
      checkOutput("p00_rgb", 32'({red, green, blue}), 32'(FG));
      gotoPixel(1, 0);
      checkOutput("p10_fs", 32'(frame_start), 32'd0);
      checkOutput("p10_ls", 32'(line_start), 32'd0);
      checkOutput("p10_x", 32'(x), 32'd1);
      gotoPixel(19, 0);
      checkOutput("p19_de", 32'(de), 32'd1);
      checkOutput("p19_x", 32'(x), 32'd19);
      gotoPixel(20, 0);
      checkOutput("p20_de", 32'(de), 32'd0);
      checkOutput("p20_x", 32'(x), 32'd0);
      checkOutput("p20_rgb", 32'({red, green, blue}), 32'd0);
      gotoPixel(21, 0);
      checkOutput("hs_before", 32'(hsync), 32'd0);
      gotoPixel(22, 0);
      checkOutput("hs_first", 32'(hsync), 32'd1);
      gotoPixel(24, 0);
      checkOutput("hs_last", 32'(hsync), 32'd1);
      gotoPixel(25, 0);
      checkOutput("hs_after", 32'(hsync), 32'd0);
      gotoPixel(0, 1);
      checkOutput("p01_ls", 32'(line_start), 32'd1);
      checkOutput("p01_fs", 32'(frame_start), 32'd0);
      checkOutput("p01_y", 32'(y), 32'd1);
      gotoPixel(0, 10);
      checkOutput("p0_10_de", 32'(de), 32'd0);
      checkOutput("p0_10_ls", 32'(line_start), 32'd0);
      checkOutput("p0_10_y", 32'(y), 32'd0);
      checkOutput("p0_10_rgb", 32'({red, green, blue}), 32'd0);
      gotoPixel(0, 11);
      checkOutput("vs_before", 32'(vsync), 32'd1);
      gotoPixel(0, 12);
      checkOutput("vs_first", 32'(vsync), 32'd0);
      gotoPixel(27, 13);
      checkOutput("vs_last", 32'(vsync), 32'd0);
      gotoPixel(0, 14);
      checkOutput("vs_after", 32'(vsync), 32'd1);

      // Whole-frame period and sync occupancy, then one line period
      gotoPixel(0, 0);
      n = 0; cnt_a = 0; cnt_b = 0;
      do begin
         stepClock();
         n++;
         if (!vsync) cnt_a++;
         if (hsync) cnt_b++;
      end while (!frame_start && n < 2000);
      trackCycles(n);
      checkOutput("frame_period", 32'(n), 32'd420);
      checkOutput("vsync_cycles", 32'(cnt_a), 32'd56);
      checkOutput("hsync_cycles", 32'(cnt_b), 32'd45);
      n = 0;
      do begin
         stepClock();
         n++;
      end while (!line_start && n < 200);
      trackCycles(n);
      checkOutput("line_period", 32'(n), 32'd28);

      // Grid mode, pitch 4
      applyReset(2'd1);
      checkRgb("grid_0_5", 0, 5, 24'h000000);
      checkRgb("grid_4_2", 4, 2, 24'h000000);
      checkRgb("grid_3_3", 3, 3, FG);
      checkRgb("grid_21_3", 21, 3, 24'h000000);
      checkRgb("grid_5_5", 5, 5, FG);
      checkRgb("grid_6_8", 6, 8, 24'h000000);
      checkRgb("grid_7_9", 7, 9, FG);
      checkRgb("grid_next_1_0", 1, 0, 24'h000000);
      checkRgb("grid_next_1_1", 1, 1, FG);

      // Colour bars, bar width 2, pixels 16..19 left in the last bar
      applyReset(2'd2);
      checkRgb("bars_x0", 0, 0, 24'hFFFFFF);
      checkRgb("bars_x1", 1, 0, 24'hFFFFFF);
      checkRgb("bars_x2", 2, 0, 24'hFFFF00);
      checkRgb("bars_x5", 5, 0, 24'h00FFFF);
      checkRgb("bars_x11", 11, 0, 24'hFF0000);
      checkRgb("bars_x13", 13, 0, 24'h0000FF);
      checkRgb("bars_x15", 15, 0, 24'h000000);
      checkRgb("bars_x17", 17, 0, 24'h000000);
      checkRgb("bars_l1_x2", 2, 1, 24'hFFFF00);
      checkRgb("bars_l1_x7", 7, 1, 24'h00FF00);
      checkRgb("bars_l1_x9", 9, 1, 24'hFF00FF);

      // Mode change mid-frame waits for the next frame
      applyReset(2'd0);
      gotoPixel(0, 5);
      applyStimulus(1'b1, 2'd2);
      checkRgb("switch_3_5", 3, 5, FG);
      checkRgb("switch_19_9", 19, 9, FG);
      checkRgb("switch_next_0_0", 0, 0, 24'hFFFFFF);
      checkOutput("switch_next_fs", 32'(frame_start), 32'd1);
      checkRgb("switch_next_2_0", 2, 0, 24'hFFFF00);

      // Reset pulse in the middle of an active line
      gotoPixel(5, 7);
      checkOutput("pulse_pre_de", 32'(de), 32'd1);
      applyStimulus(1'b0, 2'd2);
      stepClock();
      checkResetValues("pulse");
      applyStimulus(1'b1, 2'd2);
      stepClock();
      tb_h = 0;
      tb_v = 0;
      checkOutput("pulse_fs", 32'(frame_start), 32'd1);
      checkOutput("pulse_ls", 32'(line_start), 32'd1);
      checkOutput("pulse_x", 32'(x), 32'd0);
      checkOutput("pulse_y", 32'(y), 32'd0);
      checkOutput("pulse_rgb", 32'({red, green, blue}), 32'hFFFFFF);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
